// File: rtl/ibex_lsu_resp_ctrl_if.sv
// Purpose: LSU request, data-bus and writeback-response signals bundled as one port.
// Latency: none; wires only.
// Backpressure: lsu_req_ready_o gates requests, data_gnt_i gates the bus request.
interface ibex_lsu_resp_ctrl_if;
    // ID/EX request side
    logic        lsu_req_i;
    logic        lsu_we_i;
    logic [1:0]  lsu_type_i;
    logic        lsu_sign_ext_i;
    logic [31:0] lsu_addr_i;
    logic [31:0] lsu_wdata_i;
    logic        lsu_req_ready_o;
    // data bus side
    logic        data_req_o;
    logic        data_gnt_i;
    logic [31:0] data_addr_o;
    logic        data_we_o;
    logic [3:0]  data_be_o;
    logic [31:0] data_wdata_o;
    logic        data_rvalid_i;
    logic [31:0] data_rdata_i;
    logic        data_err_i;
    // writeback side
    logic        lsu_resp_valid_o;
    logic        lsu_resp_err_o;
    logic [31:0] rf_wdata_lsu_o;
    logic        rf_we_lsu_o;
    logic        busy_o;

    // The LSU is the bus master.
    modport master (
        input  lsu_req_i, lsu_we_i, lsu_type_i, lsu_sign_ext_i, lsu_addr_i, lsu_wdata_i,
        output lsu_req_ready_o,
        output data_req_o, data_addr_o, data_we_o, data_be_o, data_wdata_o,
        input  data_gnt_i, data_rvalid_i, data_rdata_i, data_err_i,
        output lsu_resp_valid_o, lsu_resp_err_o, rf_wdata_lsu_o, rf_we_lsu_o, busy_o
    );

    // ID/EX, memory and writeback together form the slave side.
    modport slave (
        output lsu_req_i, lsu_we_i, lsu_type_i, lsu_sign_ext_i, lsu_addr_i, lsu_wdata_i,
        input  lsu_req_ready_o,
        input  data_req_o, data_addr_o, data_we_o, data_be_o, data_wdata_o,
        output data_gnt_i, data_rvalid_i, data_rdata_i, data_err_i,
        input  lsu_resp_valid_o, lsu_resp_err_o, rf_wdata_lsu_o, rf_we_lsu_o, busy_o
    );
endinterface

// File: rtl/ibex_lsu_resp_ctrl.sv
// Purpose: data-side load/store sequencer, one transaction in flight, aligns stores and extends loads.
// Latency: accept at t -> data_req at t+1; zero-wait bus responds at t+2; misaligned error at t+1.
// Backpressure: lsu_req_ready_o only in IDLE or on the rvalid cycle; bus request held until gnt.
module ibex_lsu_resp_ctrl #(
    parameter bit ResetAll      = 1'b0,
    parameter int TimeoutCycles = 0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    ibex_lsu_resp_ctrl_if.master  bus
);
    typedef enum logic [1:0] {IDLE, WAIT_GNT, WAIT_RVALID, ERR} state_e;

    localparam int CntW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;

    state_e         state_q;
    logic [CntW-1:0] cnt_q;

    logic [29:0]    addr_q;
    logic [31:0]    wdata_q;
    logic [3:0]     be_q;
    logic [1:0]     type_q;
    logic [1:0]     off_q;
    logic           we_q;
    logic           sign_q;

    logic           accept;
    logic           req_misaligned;
    logic           timeout_hit;
    logic [1:0]     req_off;
    logic [3:0]     req_be;
    logic [31:0]    rdata_sh;
    logic [31:0]    load_ext;

    assign req_off = bus.lsu_addr_i[1:0];

    // Ready is allowed on the rvalid cycle so a new request overlaps the completing one.
    assign bus.lsu_req_ready_o = (state_q == IDLE) || ((state_q == WAIT_RVALID) && bus.data_rvalid_i);
    assign accept = bus.lsu_req_i && bus.lsu_req_ready_o;

    // Reserved type 11 behaves as a word access everywhere.
    assign req_misaligned = (((bus.lsu_type_i == 2'b00) || (bus.lsu_type_i == 2'b11)) && (req_off != 2'b00))
                         || ((bus.lsu_type_i == 2'b01) && (req_off == 2'b11));

    // With TimeoutCycles == 0 the compare is constant-false and the counter is don't-care.
    assign timeout_hit = (TimeoutCycles > 0) && (cnt_q == CntW'(TimeoutCycles - 1));

    // Byte enables for the incoming request.
    always_comb begin
        req_be = 4'b1111;
        case (bus.lsu_type_i)
            2'b01:   req_be = 4'b0011 << req_off;
            2'b10:   req_be = 4'b0001 << req_off;
            default: req_be = 4'b1111;
        endcase
    end

    // Request capture: store data is lane-aligned here so the bus side is a plain register.
    always_ff @(posedge clk_i) begin
        if (rst_i && ResetAll) begin
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            type_q  <= '0;
            off_q   <= '0;
            we_q    <= 1'b0;
            sign_q  <= 1'b0;
        end else if (accept) begin
            addr_q  <= bus.lsu_addr_i[31:2];
            wdata_q <= bus.lsu_wdata_i << {req_off, 3'b000};
            be_q    <= req_be;
            type_q  <= bus.lsu_type_i;
            off_q   <= req_off;
            we_q    <= bus.lsu_we_i;
            sign_q  <= bus.lsu_sign_ext_i;
        end
    end

    // Control FSM; the wait counter restarts on every state change, and a bus event beats a timeout.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (accept) begin
                        state_q <= req_misaligned ? ERR : WAIT_GNT;
                    end
                end
                WAIT_GNT: begin
                    if (bus.data_gnt_i) begin
                        state_q <= WAIT_RVALID;
                        cnt_q   <= '0;
                    end else if (timeout_hit) begin
                        state_q <= ERR;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q   <= cnt_q + CntW'(1);
                    end
                end
                WAIT_RVALID: begin
                    if (bus.data_rvalid_i) begin
                        cnt_q <= '0;
                        if (accept) begin
                            state_q <= req_misaligned ? ERR : WAIT_GNT;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else if (timeout_hit) begin
                        state_q <= ERR;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q   <= cnt_q + CntW'(1);
                    end
                end
                ERR: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    // Bus outputs are only driven while requesting so idle and reset present all-zero.
    assign bus.data_req_o   = (state_q == WAIT_GNT);
    assign bus.data_addr_o  = bus.data_req_o ? {addr_q, 2'b00} : 32'h0;
    assign bus.data_we_o    = bus.data_req_o && we_q;
    assign bus.data_be_o    = bus.data_req_o ? be_q : 4'b0000;
    assign bus.data_wdata_o = bus.data_req_o ? wdata_q : 32'h0;

    assign rdata_sh = bus.data_rdata_i >> {off_q, 3'b000};

    // Load extraction from the lane selected by the captured offset.
    always_comb begin
        load_ext = rdata_sh;
        case (type_q)
            2'b10:   load_ext = {{24{sign_q & rdata_sh[7]}},  rdata_sh[7:0]};
            2'b01:   load_ext = {{16{sign_q & rdata_sh[15]}}, rdata_sh[15:0]};
            default: load_ext = rdata_sh;
        endcase
    end

    // Response is combinational from rvalid so writeback sees it the same cycle.
    assign bus.lsu_resp_valid_o = (state_q == ERR) || ((state_q == WAIT_RVALID) && bus.data_rvalid_i);
    assign bus.lsu_resp_err_o   = (state_q == ERR)
                               || ((state_q == WAIT_RVALID) && bus.data_rvalid_i && bus.data_err_i);
    assign bus.rf_we_lsu_o      = bus.lsu_resp_valid_o && !we_q && !bus.lsu_resp_err_o;
    assign bus.rf_wdata_lsu_o   = bus.rf_we_lsu_o ? load_ext : 32'h0;
    assign bus.busy_o           = (state_q != IDLE);
endmodule

// File: tb/tb_ibex_lsu_resp_ctrl.sv
// Purpose: self-checking bench for ibex_lsu_resp_ctrl with a response scoreboard and vector table.
// Latency: inputs driven 1ns after posedge, outputs sampled on negedge.
// Backpressure: bench waits on ready/gnt timing with fixed cycle budgets only.
module tb_ibex_lsu_resp_ctrl;
    logic clk = 1'b0;
    logic rst_i;
    int   n_pass  = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    ibex_lsu_resp_ctrl_if bus();

    ibex_lsu_resp_ctrl #(.ResetAll(1'b1), .TimeoutCycles(4)) dut (
        .clk_i (clk),
        .rst_i (rst_i),
        .bus   (bus.master)
    );

    typedef struct {
        logic        we;
        logic [1:0]  typ;
        logic        sext;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        berr;
        int          gdly;
        logic        mis;
        logic [31:0] e_addr;
        logic [3:0]  e_be;
        logic [31:0] e_wdata;
        logic        e_err;
        logic        e_rfwe;
        logic [31:0] e_rf;
    } vec_t;

    typedef struct {
        logic        err;
        logic        rfwe;
        logic [31:0] rf;
    } resp_t;

    resp_t exp_q[$];
    vec_t  vecs[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        else n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic we, input logic [1:0] typ, input logic sext,
                             input logic [31:0] addr, input logic [31:0] wdata);
        bus.lsu_req_i      = 1'b1;
        bus.lsu_we_i       = we;
        bus.lsu_type_i     = typ;
        bus.lsu_sign_ext_i = sext;
        bus.lsu_addr_i     = addr;
        bus.lsu_wdata_i    = wdata;
    endtask

    task automatic push_exp(input logic err, input logic rfwe, input logic [31:0] rf);
        resp_t r;
        r.err = err; r.rfwe = rfwe; r.rf = rf;
        exp_q.push_back(r);
    endtask

    function automatic vec_t mk(input logic we, input logic [1:0] typ, input logic sext,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] rdata, input logic berr, input int gdly,
                                input logic mis, input logic [31:0] e_addr, input logic [3:0] e_be,
                                input logic [31:0] e_wdata, input logic e_err, input logic e_rfwe,
                                input logic [31:0] e_rf);
        vec_t v;
        v.we = we; v.typ = typ; v.sext = sext; v.addr = addr; v.wdata = wdata;
        v.rdata = rdata; v.berr = berr; v.gdly = gdly; v.mis = mis;
        v.e_addr = e_addr; v.e_be = e_be; v.e_wdata = e_wdata;
        v.e_err = e_err; v.e_rfwe = e_rfwe; v.e_rf = e_rf;
        return v;
    endfunction

    // One complete transaction from a table row: request, bus phase, response.
    task automatic run_vec(input vec_t v);
        drive_req(v.we, v.typ, v.sext, v.addr, v.wdata);
        push_exp(v.e_err, v.e_rfwe, v.e_rf);
        @(negedge clk);
        chk("accept_ready", bus.lsu_req_ready_o, 1);
        tick();
        bus.lsu_req_i = 1'b0;
        if (v.mis) begin
            @(negedge clk);
            chk("mis_no_req", bus.data_req_o, 0);
            chk("mis_resp_t1", bus.lsu_resp_valid_o, 1);
            tick();
        end else begin
            for (int i = 0; i <= v.gdly; i++) begin
                bus.data_gnt_i = (i == v.gdly);
                @(negedge clk);
                chk("req_high", bus.data_req_o, 1);
                chk("bus_addr", bus.data_addr_o, v.e_addr);
                chk("bus_be", {28'h0, bus.data_be_o}, {28'h0, v.e_be});
                chk("bus_wdata", bus.data_wdata_o, v.e_wdata);
                chk("bus_we", bus.data_we_o, v.we);
                tick();
            end
            bus.data_gnt_i   = 1'b0;
            bus.data_rvalid_i = 1'b1;
            bus.data_rdata_i  = v.rdata;
            bus.data_err_i    = v.berr;
            @(negedge clk);
            chk("resp_on_rvalid", bus.lsu_resp_valid_o, 1);
            chk("no_req_in_rvalid", bus.data_req_o, 0);
            tick();
            bus.data_rvalid_i = 1'b0;
            bus.data_err_i    = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_i = 1'b1;
        bus.lsu_req_i = 1'b0; bus.lsu_we_i = 1'b0; bus.lsu_type_i = 2'b00;
        bus.lsu_sign_ext_i = 1'b0; bus.lsu_addr_i = 32'h0; bus.lsu_wdata_i = 32'h0;
        bus.data_gnt_i = 1'b0; bus.data_rvalid_i = 1'b0;
        bus.data_rdata_i = 32'h0; bus.data_err_i = 1'b0;

        //      we  typ    sx addr          wdata         rdata         be gd mis e_addr        e_be     e_wdata       err rfwe e_rf
        vecs[0]  = mk(0, 2'b00, 0, 32'h100, 32'h0,        32'hDEADBEEF, 0, 0, 0, 32'h100, 4'b1111, 32'h0,        0, 1, 32'hDEADBEEF);
        vecs[1]  = mk(0, 2'b10, 1, 32'h103, 32'h0,        32'h80AA5511, 0, 0, 0, 32'h100, 4'b1000, 32'h0,        0, 1, 32'hFFFFFF80);
        vecs[2]  = mk(0, 2'b10, 0, 32'h103, 32'h0,        32'h80AA5511, 0, 0, 0, 32'h100, 4'b1000, 32'h0,        0, 1, 32'h00000080);
        vecs[3]  = mk(1, 2'b01, 0, 32'h202, 32'h1234ABCD, 32'h0,        0, 0, 0, 32'h200, 4'b1100, 32'hABCD0000, 0, 0, 32'h0);
        vecs[4]  = mk(0, 2'b00, 0, 32'h101, 32'h0,        32'h0,        0, 0, 1, 32'h0,   4'b0000, 32'h0,        1, 0, 32'h0);
        vecs[5]  = mk(0, 2'b00, 0, 32'h300, 32'h0,        32'h12345678, 1, 0, 0, 32'h300, 4'b1111, 32'h0,        1, 0, 32'h0);
        vecs[6]  = mk(0, 2'b01, 1, 32'h002, 32'h0,        32'h80017FFF, 0, 1, 0, 32'h000, 4'b1100, 32'h0,        0, 1, 32'hFFFF8001);
        vecs[7]  = mk(0, 2'b01, 0, 32'h000, 32'h0,        32'h8001F00F, 0, 0, 0, 32'h000, 4'b0011, 32'h0,        0, 1, 32'h0000F00F);
        vecs[8]  = mk(0, 2'b01, 1, 32'h003, 32'h0,        32'h0,        0, 0, 1, 32'h0,   4'b0000, 32'h0,        1, 0, 32'h0);
        vecs[9]  = mk(1, 2'b10, 0, 32'h401, 32'h000000A5, 32'h0,        0, 0, 0, 32'h400, 4'b0010, 32'h0000A500, 0, 0, 32'h0);
        vecs[10] = mk(1, 2'b00, 0, 32'h500, 32'hCAFEF00D, 32'h0,        0, 2, 0, 32'h500, 4'b1111, 32'hCAFEF00D, 0, 0, 32'h0);
        vecs[11] = mk(0, 2'b11, 1, 32'h600, 32'h0,        32'h0BADC0DE, 0, 0, 0, 32'h600, 4'b1111, 32'h0,        0, 1, 32'h0BADC0DE);
        vecs[12] = mk(0, 2'b10, 1, 32'h001, 32'h0,        32'h00007F00, 0, 0, 0, 32'h000, 4'b0010, 32'h0,        0, 1, 32'h0000007F);
        vecs[13] = mk(1, 2'b01, 0, 32'h201, 32'h1234ABCD, 32'h0,        0, 0, 0, 32'h200, 4'b0110, 32'h34ABCD00, 0, 0, 32'h0);

        // Scoreboard: every response must match the oldest outstanding expectation.
        fork
            forever begin
                @(negedge clk);
                if (bus.lsu_resp_valid_o === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        chk("resp_unexpected", bus.lsu_resp_valid_o, 0);
                    end else begin
                        resp_t r;
                        r = exp_q.pop_front();
                        chk("resp_err", bus.lsu_resp_err_o, r.err);
                        chk("rf_we", bus.rf_we_lsu_o, r.rfwe);
                        chk("rf_wdata", bus.rf_wdata_lsu_o, r.rf);
                    end
                end
            end
        join_none

        // Reset state
        repeat (2) @(posedge clk);
        #1 rst_i = 1'b0;
        @(negedge clk);
        chk("rst_ready", bus.lsu_req_ready_o, 1);
        chk("rst_data_req", bus.data_req_o, 0);
        chk("rst_resp_valid", bus.lsu_resp_valid_o, 0);
        chk("rst_busy", bus.busy_o, 0);
        chk("rst_rf_we", bus.rf_we_lsu_o, 0);
        chk("rst_addr", bus.data_addr_o, 32'h0);
        chk("rst_be", {28'h0, bus.data_be_o}, 32'h0);
        tick();

        for (int i = 0; i < 14; i++) run_vec(vecs[i]);

        // gnt held low 3 cycles, then a back-to-back request on the rvalid cycle
        drive_req(0, 2'b00, 0, 32'h700, 32'h0);
        push_exp(0, 1, 32'h11112222);
        @(negedge clk);
        tick();
        bus.lsu_req_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.data_gnt_i = (i == 3);
            @(negedge clk);
            chk("b2b_req_held", bus.data_req_o, 1);
            chk("b2b_addr_stable", bus.data_addr_o, 32'h700);
            tick();
        end
        bus.data_gnt_i = 1'b0;
        bus.data_rvalid_i = 1'b1;
        bus.data_rdata_i = 32'h11112222;
        drive_req(0, 2'b10, 0, 32'h705, 32'h0);
        push_exp(0, 1, 32'h00000033);
        @(negedge clk);
        chk("b2b_ready_on_rvalid", bus.lsu_req_ready_o, 1);
        chk("b2b_resp_first", bus.lsu_resp_valid_o, 1);
        tick();
        bus.data_rvalid_i = 1'b0;
        bus.lsu_req_i = 1'b0;
        bus.data_gnt_i = 1'b1;
        @(negedge clk);
        chk("b2b_next_req", bus.data_req_o, 1);
        chk("b2b_next_addr", bus.data_addr_o, 32'h704);
        chk("b2b_next_be", {28'h0, bus.data_be_o}, 32'h2);
        tick();
        bus.data_gnt_i = 1'b0;
        bus.data_rvalid_i = 1'b1;
        bus.data_rdata_i = 32'h00003300;
        @(negedge clk);
        chk("b2b_resp_second", bus.lsu_resp_valid_o, 1);
        tick();
        bus.data_rvalid_i = 1'b0;

        // Timeout in WAIT_GNT
        drive_req(0, 2'b00, 0, 32'h800, 32'h0);
        push_exp(1, 0, 32'h0);
        @(negedge clk);
        tick();
        bus.lsu_req_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("to_gnt_req_high", bus.data_req_o, 1);
            chk("to_gnt_no_resp", bus.lsu_resp_valid_o, 0);
            tick();
        end
        @(negedge clk);
        chk("to_gnt_req_drop", bus.data_req_o, 0);
        chk("to_gnt_resp", bus.lsu_resp_valid_o, 1);
        chk("to_gnt_ready_err", bus.lsu_req_ready_o, 0);
        tick();
        @(negedge clk);
        chk("to_gnt_idle", bus.busy_o, 0);
        tick();

        // Timeout in WAIT_RVALID
        drive_req(0, 2'b00, 0, 32'h900, 32'h0);
        push_exp(1, 0, 32'h0);
        @(negedge clk);
        tick();
        bus.lsu_req_i = 1'b0;
        bus.data_gnt_i = 1'b1;
        @(negedge clk);
        tick();
        bus.data_gnt_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("to_rv_no_req", bus.data_req_o, 0);
            chk("to_rv_busy", bus.busy_o, 1);
            tick();
        end
        @(negedge clk);
        chk("to_rv_resp_err", bus.lsu_resp_err_o, 1);
        tick();

        // Reset while in WAIT_RVALID abandons the transaction; late rvalid ignored
        drive_req(0, 2'b00, 0, 32'hA00, 32'h0);
        @(negedge clk);
        tick();
        bus.lsu_req_i = 1'b0;
        bus.data_gnt_i = 1'b1;
        @(negedge clk);
        tick();
        bus.data_gnt_i = 1'b0;
        rst_i = 1'b1;
        @(negedge clk);
        tick();
        rst_i = 1'b0;
        @(negedge clk);
        chk("rst_mid_ready", bus.lsu_req_ready_o, 1);
        chk("rst_mid_busy", bus.busy_o, 0);
        tick();
        bus.data_rvalid_i = 1'b1;
        bus.data_rdata_i = 32'hFFFFFFFF;
        @(negedge clk);
        chk("late_rvalid_ignored", bus.lsu_resp_valid_o, 0);
        chk("late_rvalid_rf_we", bus.rf_we_lsu_o, 0);
        tick();
        bus.data_rvalid_i = 1'b0;

        repeat (2) tick();
        chk("sb_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
